// File: rtl/act_interp_pipe.sv
// Pipelined piecewise-linear activation: splits x into table index and remainder,
// fetches two adjacent points from a run-time loadable table and interpolates.
module act_interp_pipe #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tbl_we,
    input  logic [IDX_W-1:0]  tbl_addr,
    input  logic [DATA_W-1:0] tbl_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);
    localparam int REM_W  = DATA_W - IDX_W;
    localparam int DEPTH  = 2 ** IDX_W;
    localparam int PROD_W = DATA_W + REM_W + 2;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(1) << (IDX_W - 1);

    logic adv;

    logic [DATA_W-1:0] tbl [DEPTH];

    // S0: accepted sample
    logic              v0;
    logic [DATA_W-1:0] x0;

    // Lookup, combinational from S0
    logic [IDX_W-1:0]         idx;
    logic [REM_W-1:0]         rem;
    logic signed [DATA_W-1:0] base;
    logic signed [DATA_W-1:0] nxt;
    logic signed [DATA_W:0]   delta;

    // S1: lookup results
    logic                     v1;
    logic signed [DATA_W:0]   delta1;
    logic [REM_W-1:0]         rem1;
    logic signed [DATA_W-1:0] base1;

    // S2: product
    logic                     v2;
    logic signed [PROD_W-1:0] prod2;
    logic signed [DATA_W-1:0] base2;

    logic signed [PROD_W-1:0] delta_ext;
    logic signed [PROD_W-1:0] rem_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shifted;
    logic signed [PROD_W-1:0] base_ext;
    logic signed [PROD_W-1:0] sum;
    logic                     unused_sum_hi;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Offset-binary index: flipping the MSB maps the most negative x to entry 0.
    always_comb begin
        idx   = x0[DATA_W-1 -: IDX_W] ^ IDX_MSB;
        rem   = x0[REM_W-1:0];
        base  = tbl[idx];
        nxt   = (&idx) ? base : tbl[idx + IDX_W'(1)];
        delta = {nxt[DATA_W-1], nxt} - {base[DATA_W-1], base};
    end

    // Both operands are widened to the product width before the multiply so the
    // signed product is exact; the final add is kept in its own signed context so
    // the shift stays arithmetic.
    always_comb begin
        delta_ext = {{(REM_W + 1){delta1[DATA_W]}}, delta1};
        rem_ext   = {{(DATA_W + 2){1'b0}}, rem1};
        prod      = delta_ext * rem_ext;
        shifted   = prod2 >>> REM_W;
        base_ext  = {{(REM_W + 2){base2[DATA_W-1]}}, base2};
        sum       = base_ext + shifted;
    end

    // The interpolated value always lies between two table entries, so the
    // upper bits of the sum carry only sign extension.
    assign unused_sum_hi = ^sum[PROD_W-1:DATA_W];

    // NOTE: the table is a register file with a synchronous clear, not a RAM
    // macro; a run-time reset must return every entry to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= '0;
            end
        end else if (tbl_we) begin
            tbl[tbl_addr] <= tbl_data;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every stage samples
    // the previous stage's value from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            v0        <= 1'b0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (adv) begin
            v0        <= in_valid;
            v1        <= v0;
            v2        <= v1;
            out_valid <= v2;
            if (v2) begin
                out_data <= sum[DATA_W-1:0];
            end
        end
    end

    // Datapath registers need no reset: they are only consumed under their valid bit.
    always_ff @(posedge clk) begin
        if (adv) begin
            if (in_valid) begin
                x0 <= in_data;
            end
            if (v0) begin
                delta1 <= delta;
                rem1   <= rem;
                base1  <= base;
            end
            if (v1) begin
                prod2 <= prod;
                base2 <= base1;
            end
        end
    end

endmodule

// File: tb/tb_act_interp_pipe.sv
// Self-checking bench for act_interp_pipe: directed vector table, multi-cycle
// corner sequences and randomized traffic against a scoreboard model.
module tb_act_interp_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       tbl_we;
    logic [3:0] tbl_addr;
    logic [7:0] tbl_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    act_interp_pipe #(.DATA_W(8), .IDX_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .tbl_we   (tbl_we),
        .tbl_addr (tbl_addr),
        .tbl_data (tbl_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a_idx;
        logic [7:0] a_val;
        logic [3:0] b_idx;
        logic [7:0] b_val;
        logic [7:0] x;
        logic [7:0] exp;
    } vec_t;

    int         n_vec = 0;
    int         n_err = 0;
    int         n_out = 0;
    int         model_tbl [16];
    logic [7:0] exp_q [$];
    bit         stall_prev = 1'b0;
    logic [7:0] held;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    // Reference: x + 128 split into 16 segments of 16 steps, floor-interpolated.
    function automatic logic [7:0] ref_out(logic [7:0] x);
        int u, seg, frac, b, n, p, q;
        u    = int'($signed(x)) + 128;
        seg  = u / 16;
        frac = u % 16;
        b    = model_tbl[seg];
        n    = (seg == 15) ? b : model_tbl[seg + 1];
        p    = (n - b) * frac;
        q    = (p >= 0) ? p / 16 : -((-p + 15) / 16);
        return 8'(b + q);
    endfunction

    // Scoreboard and protocol monitor, sampling midway between rising edges.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            foreach (model_tbl[i]) model_tbl[i] = 0;
            stall_prev = 1'b0;
        end else begin
            check("in_ready", in_ready, !out_valid || out_ready);
            if (stall_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, held);
            end
            if (out_valid && out_ready) begin
                n_out++;
                check("out_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("out_data", out_data, exp_q.pop_front());
            end
            if (tbl_we) model_tbl[tbl_addr] = int'($signed(tbl_data));
            if (in_valid && in_ready) exp_q.push_back(ref_out(in_data));
            stall_prev = out_valid && !out_ready;
            held       = out_data;
        end
    end

    task automatic write_tbl(input logic [3:0] a, input logic [7:0] d);
        tbl_we = 1'b1; tbl_addr = a; tbl_data = d;
        @(posedge clk); #1;
        tbl_we = 1'b0;
    endtask

    task automatic send(input logic [7:0] x);
        int t = 0;
        in_valid = 1'b1; in_data = x;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("send_accepted", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts rising edges after the accept edge until out_valid is seen.
    task automatic wait_out(output int lat, output logic [7:0] d);
        lat = 0;
        forever begin
            @(negedge clk);
            if (out_valid || lat >= 20) break;
            lat++;
        end
        d = out_data;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs [8];
        int         lat;
        logic [7:0] d;
        logic [7:0] pending [$];
        int         out_start;
        int         stalls;

        vecs[0] = '{4'd8,  8'h10, 4'd9,  8'h30, 8'h08, 8'h20};
        vecs[1] = '{4'd8,  8'h30, 4'd9,  8'h10, 8'h04, 8'h28};
        vecs[2] = '{4'd0,  8'h7F, 4'd1,  8'h80, 8'h8F, 8'h8F};
        vecs[3] = '{4'd15, 8'h55, 4'd14, 8'h00, 8'h7F, 8'h55};
        vecs[4] = '{4'd15, 8'h55, 4'd0,  8'h7F, 8'h7F, 8'h55};
        vecs[5] = '{4'd0,  8'h7F, 4'd1,  8'h80, 8'h80, 8'h7F};
        vecs[6] = '{4'd3,  8'hF0, 4'd4,  8'h10, 8'hB5, 8'hFA};
        vecs[7] = '{4'd5,  8'h05, 4'd6,  8'h00, 8'hD1, 8'h04};

        rst = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_in_ready", in_ready, 1);

        // Directed interpolation points, each with its own latency check.
        for (int i = 0; i < 8; i++) begin
            write_tbl(vecs[i].a_idx, vecs[i].a_val);
            write_tbl(vecs[i].b_idx, vecs[i].b_val);
            send(vecs[i].x);
            wait_out(lat, d);
            check("vec_latency", lat, 3);
            check("vec_data", d, vecs[i].exp);
        end

        // Table write in the same cycle as the lookup sees the old entry.
        write_tbl(4'd8, 8'h10);
        send(8'h00);
        write_tbl(4'd8, 8'h40);
        wait_out(lat, d);
        check("wr_during_lookup", d, 8'h10);
        send(8'h00);
        wait_out(lat, d);
        check("wr_after_lookup", d, 8'h40);

        // Back-to-back stream with a downstream stall.
        @(posedge clk); #1;
        pending   = '{8'h00, 8'h10, 8'h20, 8'h30};
        out_start = n_out;
        stalls    = 0;
        for (int c = 0; c < 40; c++) begin
            if (pending.size() == 0 && exp_q.size() == 0 && c >= 8) break;
            in_valid  = pending.size() > 0;
            in_data   = (pending.size() > 0) ? pending[0] : 8'h00;
            out_ready = !(c >= 2 && c < 7);
            @(negedge clk);
            if (!in_ready) stalls++;
            if (in_valid && in_ready) void'(pending.pop_front());
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_stall_cycles", stalls, 3);
        check("stream_results", n_out - out_start, 4);
        check("stream_drained", exp_q.size(), 0);

        // Reset with three samples in flight.
        write_tbl(4'd8, 8'h22);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'(i * 16);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_no_output", out_valid, 0);
        end
        send(8'h00);
        wait_out(lat, d);
        check("rst_tbl_cleared", d, 8'h00);

        // Randomized traffic with random back-pressure over a random table.
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) write_tbl(4'(i), 8'($urandom));
        for (int c = 0; c < 400; c++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            in_data   = 8'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            @(posedge clk); #1;
        end
        check("random_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
